// File: rtl/dispense_pkg.sv
// dispense_pkg: shared types and time-field widths for the dose scheduler.
package dispense_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_e;
  typedef struct packed {
    logic              en;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } slot_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dispense_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requesting channel after last, wrapping around.
module rr_arbiter
  import dispense_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         valid
);
  logic [W-1:0] j;
  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(last) + i) % N);
      if (req[j]) grant = j;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/dispense_scheduler.sv
// dispense_scheduler: matches dose times per channel and serialises motor pulses
// through a round-robin arbiter, with a per-dose acknowledge alarm and miss counter.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int NUM_SLOTS     = 3,
  parameter int PULSE_CYCLES  = 50_000_000,
  parameter int GAP_CYCLES    = 5_000_000,
  parameter int ACK_TIMEOUT_S = 600
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         sec_tick,
  input  logic [HOUR_W-1:0]            hours,
  input  logic [MIN_W-1:0]             minutes,
  input  logic [SEC_W-1:0]             seconds,
  input  logic                         cfg_we,
  input  logic [idx_w(NUM_CH)-1:0]     cfg_ch,
  input  logic [idx_w(NUM_SLOTS)-1:0]  cfg_slot,
  input  logic                         cfg_en,
  input  logic [HOUR_W-1:0]            cfg_hour,
  input  logic [MIN_W-1:0]             cfg_min,
  input  logic [NUM_CH-1:0]            ov_req,
  input  logic                         ack,
  output logic [NUM_CH-1:0]            dispense,
  output logic                         busy,
  output logic [NUM_CH-1:0]            pending,
  output logic                         alarm,
  output logic [7:0]                   missed_count
);
  localparam int CW    = idx_w(NUM_CH);
  localparam int CNT_W = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
  localparam int TW    = $clog2(ACK_TIMEOUT_S + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]      last_q, last_d;
  logic [NUM_CH-1:0]  disp_q, disp_d, pend_q, pend_d;
  logic               alarm_q, alarm_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [7:0]         miss_q, miss_d;
  slot_t              tbl_q [NUM_CH][NUM_SLOTS];
  slot_t              tbl_d [NUM_CH][NUM_SLOTS];
  logic [NUM_CH-1:0]  match, req;
  logic [CW-1:0]      arb_grant;
  logic               arb_valid, deliver, miss_ev;

  rr_arbiter #(.N(NUM_CH), .W(CW)) u_arb (
    .req   (pend_q),
    .last  (last_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    match = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < NUM_SLOTS; s++)
        if (tbl_q[c][s].en && tbl_q[c][s].hour == hours && tbl_q[c][s].min == minutes) match[c] = 1'b1;
  end

  assign req = ov_req | ((sec_tick && seconds == '0) ? match : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    disp_d  = disp_q;
    pend_d  = pend_q | req;
    tbl_d   = tbl_q;
    deliver = 1'b0;
    if (cfg_we && int'(cfg_ch) < NUM_CH && int'(cfg_slot) < NUM_SLOTS)
      tbl_d[cfg_ch][cfg_slot] = '{en: cfg_en && cfg_hour <= 5'd23 && cfg_min <= 6'd59,
                                  hour: cfg_hour, min: cfg_min};
    if (state_q == IDLE && arb_valid) begin
      state_d           = DRIVE;
      cnt_d             = CNT_W'(PULSE_CYCLES - 1);
      last_d            = arb_grant;
      disp_d            = NUM_CH'(1) << arb_grant;
      pend_d[arb_grant] = req[arb_grant];
    end else if (state_q == DRIVE) begin
      cnt_d = cnt_q == '0 ? CNT_W'(GAP_CYCLES - 1) : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = GAP;
        disp_d  = '0;
        deliver = 1'b1;
      end
    end else if (state_q == GAP) begin
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      state_d = cnt_q == '0 ? IDLE : GAP;
    end
    // A fresh delivery over an unacknowledged one retires the old dose as missed.
    miss_ev = alarm_q && !ack && (deliver || (sec_tick && tmr_q == TW'(1)));
    alarm_d = deliver || (alarm_q && !ack && !miss_ev);
    tmr_d   = deliver ? TW'(ACK_TIMEOUT_S)
            : (alarm_q && sec_tick && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    miss_d  = (miss_ev && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= CW'(NUM_CH - 1);
      disp_q  <= '0;
      pend_q  <= '0;
      alarm_q <= 1'b0;
      tmr_q   <= '0;
      miss_q  <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_SLOTS; s++)
          tbl_q[c][s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      alarm_q <= alarm_d;
      tmr_q   <= tmr_d;
      miss_q  <= miss_d;
      tbl_q   <= tbl_d;
    end
  end

  assign dispense     = disp_q;
  assign busy         = state_q != IDLE;
  assign pending      = pend_q;
  assign alarm        = alarm_q;
  assign missed_count = miss_q;
endmodule

// File: tb/tb_dispense_scheduler.sv
// tb_dispense_scheduler: scoreboard bench; expected grant order is queued at
// stimulus time and popped on every rising dispense.
module tb_dispense_scheduler;
  localparam int NC = 4;
  localparam int P  = 10;
  localparam int G  = 4;
  localparam int A  = 3;

  logic clk = 1'b0, resetn = 1'b0, sec_tick = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, ack = 1'b0;
  logic [4:0] hours = '0, cfg_hour = '0;
  logic [5:0] minutes = '0, seconds = '0, cfg_min = '0;
  logic [1:0] cfg_ch = '0, cfg_slot = '0;
  logic [NC-1:0] ov_req = '0;
  logic [NC-1:0] dispense, pending;
  logic busy, alarm;
  logic [7:0] missed_count;

  int n_vec = 0, n_err = 0, cyc_n = 0, mon_hi = 0;
  logic [NC-1:0] mon_prev = '0;
  int exp_q[$];
  int rise_t[$];

  dispense_scheduler #(
    .NUM_CH(NC), .NUM_SLOTS(3), .PULSE_CYCLES(P), .GAP_CYCLES(G), .ACK_TIMEOUT_S(A)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .sec_tick(sec_tick), .hours(hours), .minutes(minutes),
    .seconds(seconds), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
    .cfg_hour(cfg_hour), .cfg_min(cfg_min), .ov_req(ov_req), .ack(ack), .dispense(dispense),
    .busy(busy), .pending(pending), .alarm(alarm), .missed_count(missed_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int sl, input logic en, input int h, input int m);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_slot = 2'(sl); cfg_en = en; cfg_hour = 5'(h); cfg_min = 6'(m);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic ov(input int ch);
    ov_req = NC'(1) << ch;
    exp_q.push_back(ch);
    step();
    ov_req = '0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic wait_alarm();
    for (int k = 0; k < 100 && !alarm; k++) @(negedge clk);
    if (!alarm) check("wait_alarm", 32'(alarm), 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && pending == '0) break;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step();
    rise_t.delete();
  endtask

  // Monitor: grant order, one-hot drive, pulse width, alarm at falling edge.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mon_prev = '0;
      mon_hi = 0;
    end else begin
      if (dispense != '0) check("onehot", 32'($onehot(dispense)), 1);
      if (dispense != '0 && mon_prev == '0) begin
        rise_t.push_back(cyc_n);
        if (exp_q.size() == 0) check("unexpected", 32'(dispense), 0);
        else check("grant", 32'(dispense), 32'(1) << exp_q.pop_front());
        mon_hi = 1;
      end else if (dispense != '0) begin
        mon_hi++;
      end else if (mon_prev != '0) begin
        check("width", mon_hi, P);
        check("alarm_rise", 32'(alarm), 1);
      end
      mon_prev = dispense;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    @(negedge clk);
    check("rst_disp", 32'(dispense), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_miss", 32'(missed_count), 0);
    resetn = 1'b1;
    step();
    // out-of-range hour is stored disabled and must never match
    write(0, 0, 1'b1, 24, 0);
    write(1, 0, 1'b1, 8, 0);
    hours = 24; minutes = 0; seconds = 0;
    tick();
    @(negedge clk);
    check("h24_pend", 32'(pending), 0);
    step();
    check("h24_busy", 32'(busy), 0);
    hours = 8;
    exp_q.push_back(1);
    tick();
    @(negedge clk);
    check("t1_pend", 32'(pending), 32'h2);
    check("t1_disp_early", 32'(dispense), 0);
    @(negedge clk);
    check("t1_disp", 32'(dispense), 32'h2);
    check("t1_pend_clr", 32'(pending), 0);
    wait_alarm();
    check("t1_fall", 32'(dispense), 0);
    check("t1_miss", 32'(missed_count), 0);
    pulse_ack();
    @(negedge clk);
    check("t1_ack", 32'(alarm), 0);
    check("t1_miss_ack", 32'(missed_count), 0);
    wait_idle();

    // simultaneous match on ch0,ch2,ch3 (ch2 twice) from reset order
    do_reset();
    write(0, 2, 1'b1, 9, 30);
    write(2, 1, 1'b1, 9, 30);
    write(2, 2, 1'b1, 9, 30);
    write(3, 0, 1'b1, 9, 30);
    hours = 9; minutes = 30; seconds = 0;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    tick();
    wait_idle();
    check("t2_nrise", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      check("t2_space01", rise_t[1] - rise_t[0], P + G + 1);
      check("t2_space12", rise_t[2] - rise_t[1], P + G + 1);
    end
    check("t2_miss", 32'(missed_count), 2);
    check("t2_alarm", 32'(alarm), 1);

    // override merging and re-request during drive
    pulse_ack();
    @(negedge clk);
    check("t3_ack", 32'(alarm), 0);
    minutes = 31;
    ov(0);
    step(3);
    ov(2);
    exp_q.pop_back();
    step();
    ov(2);
    @(negedge clk);
    check("t3_pend_merge", 32'(pending), 32'h4);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dispense == 4'b0100) break;
    end
    check("t3_wait_ch2", 32'(dispense), 32'h4);
    ov(2);
    wait_idle();
    check("t3_miss", 32'(missed_count), 4);
    check("t3_alarm", 32'(alarm), 1);

    // ack timeout, then ack coinciding with timeout
    seconds = 5;
    tick(); @(negedge clk); check("t4_tick1", 32'(alarm), 1);
    tick(); @(negedge clk); check("t4_tick2", 32'(alarm), 1);
    tick(); @(negedge clk);
    check("t4_timeout_alarm", 32'(alarm), 0);
    check("t4_timeout_miss", 32'(missed_count), 5);
    ov(1);
    wait_alarm();
    tick(); tick();
    ack = 1'b1; sec_tick = 1'b1;
    step();
    ack = 1'b0; sec_tick = 1'b0;
    @(negedge clk);
    check("t4_ackwin_alarm", 32'(alarm), 0);
    check("t4_ackwin_miss", 32'(missed_count), 5);
    wait_idle();

    // asynchronous reset in the middle of a drive
    ov(3);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dispense != '0) break;
    end
    step(2);
    #2 resetn = 1'b0;
    #1;
    check("t6_disp", 32'(dispense), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_pend", 32'(pending), 0);
    check("t6_alarm", 32'(alarm), 0);
    check("t6_miss", 32'(missed_count), 0);
    step(2);
    resetn = 1'b1;
    step();

    // saturation of missed_count through repeated timeouts
    seconds = 5;
    for (int i = 0; i < 260; i++) begin
      ov(i % NC);
      wait_alarm();
      tick(); tick(); tick();
      @(negedge clk);
      check("t7_sat", 32'(missed_count), (i + 1 > 255) ? 255 : i + 1);
    end
    check("t7_alarm", 32'(alarm), 0);
    wait_idle();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
